// File: rtl/tanh_act_seq.sv
// Requantizes signed MAC accumulator words to the Q7 tanh LUT address,
// captures the LUT result (or the linear value) and hands it downstream with layer framing.
module tanh_act_seq #(
  parameter int N          = 8,
  parameter int Q          = 7,
  parameter int ACC_W      = 16,
  parameter int ACC_Q      = 14,
  parameter int LAYER_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             layer_start,
  input  logic             act_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_acc,
  output logic [N-1:0]     lut_addr,
  input  logic [N-1:0]     lut_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_last
);

  localparam int SH    = ACC_Q - Q;
  localparam int CNT_W = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(LAYER_SIZE - 1);
  localparam logic signed [ACC_W:0]   HALF     = (ACC_W+1)'(2 ** (SH - 1));
  localparam logic signed [ACC_W:0]   Q_MAX    = (ACC_W+1)'(2 ** (N - 1) - 1);
  localparam logic signed [ACC_W:0]   Q_MIN    = ~Q_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOK,
    S_OUT
  } state_t;

  // Round half up by adding half an output LSB before the arithmetic shift;
  // one guard bit keeps the addition from overflowing at the positive extreme.
  function automatic logic signed [ACC_W:0] round_shift(input logic [ACC_W-1:0] acc);
    logic signed [ACC_W:0] r;
    r = $signed({acc[ACC_W-1], acc}) + HALF;
    return r >>> SH;
  endfunction

  function automatic logic [N-1:0] saturate(input logic signed [ACC_W:0] v);
    logic signed [ACC_W:0] s;
    if (v > Q_MAX) begin
      s = Q_MAX;
    end else if (v < Q_MIN) begin
      s = Q_MIN;
    end else begin
      s = v;
    end
    return s[N-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [N-1:0]     lut_addr_q, lut_addr_d;
  logic [N-1:0]     lin_q, lin_d;
  logic             act_q, act_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N-1:0]     quant;

  assign quant = saturate(round_shift(in_acc));

  always_comb begin
    state_d     = state_q;
    lut_addr_d  = lut_addr_q;
    lin_d       = lin_q;
    act_d       = act_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    count_d     = count_q;
    in_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lut_addr_d = quant;
          lin_d      = quant;
          act_d      = act_en;
          state_d    = S_LOOK;
        end
      end
      // The LUT has sampled lut_addr on the intervening negedge, so lut_data is current here.
      S_LOOK: begin
        out_data_d  = act_q ? lut_data : lin_q;
        out_valid_d = 1'b1;
        out_last_d  = (count_q == CNT_LAST);
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          count_d     = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A layer restart overrides any increment from a coincident handshake.
    if (layer_start) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lut_addr_q  <= '0;
      lin_q       <= '0;
      act_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      lut_addr_q  <= lut_addr_d;
      lin_q       <= lin_d;
      act_q       <= act_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
    end
  end

  assign lut_addr  = lut_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
